// File: rtl/video_upscaler_reader.sv
// Frame-buffer reader with 2x nearest-neighbour upscale: each source row is fetched once,
// emitted twice per word on the even output row, then replayed from a line buffer on the odd row.
module video_upscaler_reader #(
  parameter int unsigned SRC_WIDTH  = 160,
  parameter int unsigned SRC_HEIGHT = 120,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [15:0]       fb_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       pixel_out,
  output logic [9:0]        x_out,
  output logic [8:0]        y_out,
  output logic              sof_out,
  output logic              eol_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned SXW = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;
  localparam int unsigned RDW = $clog2(SRC_WIDTH + 1);
  localparam int unsigned SYW = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1;
  localparam logic [9:0]     X_LAST  = 10'(2 * SRC_WIDTH - 1);
  localparam logic [8:0]     Y_END   = 9'(2 * SRC_HEIGHT);
  localparam logic [RDW-1:0] RD_END  = RDW'(SRC_WIDTH);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SRC_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, REPLAY, DONE} state_t;

  state_t state, state_next;

  logic [9:0]     px;          // position of the next pixel to load into the output stage
  logic [8:0]     py;
  logic [SYW-1:0] sy;
  logic [RDW-1:0] rd_sx;
  logic           rd_pending;
  logic           pf_valid;
  logic [15:0]    pf_data;
  logic [15:0]    linebuf [SRC_WIDTH];

  logic           xfer, advance, loading, word_avail, need_word, consume, load, row_end;
  logic [15:0]    word;
  logic [SXW-1:0] sx_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = FETCH;
      FETCH:   if (xfer && row_end) state_next = REPLAY;
      REPLAY:  if (xfer && row_end) state_next = (sy == SY_LAST) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load selection follows the row being loaded (py), while the FSM follows the row on the
  // output; this lets the first replay pixel load on the same edge the fetch row completes.
  always_comb begin
    xfer       = out_valid && out_ready;
    advance    = !out_valid || out_ready;
    row_end    = out_valid && (x_out == X_LAST);
    loading    = ((state == FETCH) || (state == REPLAY)) && (py < Y_END);
    word_avail = pf_valid || rd_pending;
    word       = pf_valid ? pf_data : fb_rd_data;
    need_word  = advance && loading && !py[0] && !px[0];
    consume    = need_word && word_avail;
    load       = advance && loading && (py[0] || px[0] || word_avail);
    sx_idx     = px[SXW:1];
  end

  always_comb begin
    fb_rd_en   = (state == FETCH) && (rd_sx < RD_END) && !rd_pending && (!pf_valid || consume);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    sof_out    = out_valid && (x_out == '0) && (y_out == '0);
    eol_out    = row_end;
    fb_rd_addr = ADDR_W'(sy) * ADDR_W'(SRC_WIDTH) + ADDR_W'(rd_sx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px         <= '0;
      py         <= '0;
      sy         <= '0;
      rd_sx      <= '0;
      rd_pending <= 1'b0;
      pf_valid   <= 1'b0;
      pf_data    <= '0;
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      x_out      <= '0;
      y_out      <= '0;
    end else begin
      if ((state == IDLE) && frame_start) begin
        px <= '0;
        py <= '0;
        sy <= '0;
      end else begin
        if (load) begin
          x_out <= px;
          y_out <= py;
          if (py[0])       pixel_out <= linebuf[sx_idx];
          else if (!px[0]) pixel_out <= word;
          if (px == X_LAST) begin
            px <= '0;
            py <= py + 1'b1;
          end else begin
            px <= px + 1'b1;
          end
        end
        if ((state == REPLAY) && xfer && row_end) sy <= sy + 1'b1;
      end
      if (advance) out_valid <= load;
      rd_pending <= fb_rd_en;
      if (state != FETCH) rd_sx <= '0;
      else if (fb_rd_en)  rd_sx <= rd_sx + 1'b1;
      // At most one word is ever outstanding, so an arriving word never finds the register full.
      if (rd_pending) begin
        pf_valid <= !consume;
        pf_data  <= fb_rd_data;
      end else if (consume) begin
        pf_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (consume) linebuf[sx_idx] <= word;
  end

endmodule
